// File: rtl/bp_gshare_multi.sv
// Multi-lane gshare predictor: XOR-indexed saturating-counter PHT plus tagged BTB, with a PHT init sweep after reset.
// Predictions are combinational; train/recover/history updates land on the next rising edge. Optional macro: BP_PERF_CNT_EN.
module bp_gshare_multi #(
    parameter int GH          = 8,
    parameter int PHT_BITS    = 8,
    parameter int CTR_BITS    = 2,
    parameter int BTB_BITS    = 6,
    parameter int TAG_BITS    = 8,
    parameter int FETCH_WIDTH = 2
) (
    input  logic                        clock_i,
    input  logic                        reset_i,
    output logic                        ready_o,
    input  logic [FETCH_WIDTH-1:0]      predict_req_valid_i,
    input  logic [FETCH_WIDTH*32-1:0]   predict_req_pc_i,
    input  logic [FETCH_WIDTH-1:0]      predict_req_used_i,
    output logic [FETCH_WIDTH-1:0]      predict_taken_o,
    output logic [FETCH_WIDTH*32-1:0]   predict_target_o,
    output logic [FETCH_WIDTH*GH-1:0]   predict_ghr_snapshot_o,
    input  logic                        train_valid_i,
    input  logic [31:0]                 train_pc_i,
    input  logic                        train_actual_taken_i,
    input  logic [31:0]                 train_actual_target_i,
    input  logic [GH-1:0]               train_ghr_snapshot_i,
    input  logic                        recover_mispredict_pulse_i,
    input  logic [GH-1:0]               recover_ghr_snapshot_i,
    input  logic                        recover_actual_taken_i
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0]                 stat_train_count_o,
    output logic [31:0]                 stat_recover_count_o
`endif
);

    localparam int PHT_ENTRIES = 1 << PHT_BITS;
    localparam int BTB_ENTRIES = 1 << BTB_BITS;
    localparam logic [PHT_BITS-1:0] PHT_LAST = '1;
    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_INIT = {1'b0, {(CTR_BITS-1){1'b1}}};

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  w_run;
    logic [PHT_BITS-1:0]   r_ptr;
    logic [GH-1:0]         r_ghr;
    logic [CTR_BITS-1:0]   r_pht     [PHT_ENTRIES];
    logic [BTB_ENTRIES-1:0] r_btb_vld;
    logic [TAG_BITS-1:0]   r_btb_tag [BTB_ENTRIES];
    logic [31:0]           r_btb_tgt [BTB_ENTRIES];
    logic [GH-1:0]         w_hist    [FETCH_WIDTH+1];

    always_ff @(posedge clock_i) begin
        if (reset_i) r_state <= ST_INIT;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_INIT: if (r_ptr == PHT_LAST) w_state_nxt = ST_RUN;
            ST_RUN:  w_state_nxt = ST_RUN;
            default: w_state_nxt = ST_INIT;
        endcase
    end

    always_comb begin
        w_run   = (r_state == ST_RUN);
        ready_o = w_run;
    end

    always_ff @(posedge clock_i) begin
        if (reset_i)     r_ptr <= '0;
        else if (!w_run) r_ptr <= r_ptr + 1'b1;
    end

    // Lane history chain: each used lane shifts its own prediction in for the lanes after it.
    assign w_hist[0] = r_ghr;

    for (genvar g = 0; g < FETCH_WIDTH; g++) begin : g_lane
        logic [PHT_BITS-1:0] w_pidx;
        logic [BTB_BITS-1:0] w_bidx;
        logic [TAG_BITS-1:0] w_tag;
        logic                w_tk;

        assign w_pidx = predict_req_pc_i[g*32+2 +: PHT_BITS] ^ PHT_BITS'(w_hist[g]);
        assign w_bidx = predict_req_pc_i[g*32+2 +: BTB_BITS];
        assign w_tag  = predict_req_pc_i[g*32+BTB_BITS+2 +: TAG_BITS];
        assign w_tk   = w_run && predict_req_valid_i[g] && r_pht[w_pidx][CTR_BITS-1]
                        && r_btb_vld[w_bidx] && (r_btb_tag[w_bidx] == w_tag);

        assign predict_taken_o[g]                 = w_tk;
        assign predict_target_o[g*32 +: 32]       = w_tk ? r_btb_tgt[w_bidx] : 32'd0;
        assign predict_ghr_snapshot_o[g*GH +: GH] = w_hist[g];
        assign w_hist[g+1] = (w_run && predict_req_valid_i[g] && predict_req_used_i[g])
                             ? {w_hist[g][GH-2:0], w_tk} : w_hist[g];
    end

    logic                w_train;
    logic                w_recover;
    logic [PHT_BITS-1:0] w_tr_pidx;
    logic [BTB_BITS-1:0] w_tr_bidx;
    logic [TAG_BITS-1:0] w_tr_tag;
    logic [CTR_BITS-1:0] w_tr_ctr;
    logic [CTR_BITS-1:0] w_tr_ctr_nxt;
    logic                w_unused;

    assign w_train   = w_run && train_valid_i;
    assign w_recover = w_run && recover_mispredict_pulse_i;
    assign w_tr_pidx = train_pc_i[PHT_BITS+1:2] ^ PHT_BITS'(train_ghr_snapshot_i);
    assign w_tr_bidx = train_pc_i[BTB_BITS+1:2];
    assign w_tr_tag  = train_pc_i[BTB_BITS+TAG_BITS+1:BTB_BITS+2];
    assign w_tr_ctr  = r_pht[w_tr_pidx];
    assign w_unused  = ^{predict_req_pc_i, train_pc_i, recover_ghr_snapshot_i[GH-1]};

    always_comb begin
        w_tr_ctr_nxt = w_tr_ctr;
        if (train_actual_taken_i) begin
            if (w_tr_ctr != CTR_MAX) w_tr_ctr_nxt = w_tr_ctr + 1'b1;
        end else if (w_tr_ctr != '0) begin
            w_tr_ctr_nxt = w_tr_ctr - 1'b1;
        end
    end

    // PHT has no reset of its own: the INIT sweep rewrites every entry.
    always_ff @(posedge clock_i) begin
        if (!reset_i) begin
            if (!w_run)       r_pht[r_ptr]     <= CTR_INIT;
            else if (w_train) r_pht[w_tr_pidx] <= w_tr_ctr_nxt;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i)                                r_btb_vld            <= '0;
        else if (w_train && train_actual_taken_i)   r_btb_vld[w_tr_bidx] <= 1'b1;
    end

    always_ff @(posedge clock_i) begin
        if (!reset_i && w_train && train_actual_taken_i) begin
            r_btb_tag[w_tr_bidx] <= w_tr_tag;
            r_btb_tgt[w_tr_bidx] <= train_actual_target_i;
        end
    end

    // Recovery overrides the speculative shift from this cycle's used lanes.
    always_ff @(posedge clock_i) begin
        if (reset_i)        r_ghr <= '0;
        else if (w_recover) r_ghr <= {recover_ghr_snapshot_i[GH-2:0], recover_actual_taken_i};
        else if (w_run)     r_ghr <= w_hist[FETCH_WIDTH];
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] r_train_cnt;
    logic [31:0] r_recover_cnt;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_train_cnt   <= '0;
            r_recover_cnt <= '0;
        end else begin
            if (w_train && (r_train_cnt != 32'hFFFF_FFFF))     r_train_cnt   <= r_train_cnt + 32'd1;
            if (w_recover && (r_recover_cnt != 32'hFFFF_FFFF)) r_recover_cnt <= r_recover_cnt + 32'd1;
        end
    end

    assign stat_train_count_o   = r_train_cnt;
    assign stat_recover_count_o = r_recover_cnt;
`endif

endmodule

// File: tb/tb_bp_gshare_multi.sv
// Bench for bp_gshare_multi (GH=4, PHT_BITS=4, BTB_BITS=4, two lanes): directed vector table plus
// randomized traffic checked against an arithmetic model of the predictor tables and history.
module tb_bp_gshare_multi;

    logic        clock_i;
    logic        reset_i;
    logic        ready_o;
    logic [1:0]  predict_req_valid_i;
    logic [63:0] predict_req_pc_i;
    logic [1:0]  predict_req_used_i;
    logic [1:0]  predict_taken_o;
    logic [63:0] predict_target_o;
    logic [7:0]  predict_ghr_snapshot_o;
    logic        train_valid_i;
    logic [31:0] train_pc_i;
    logic        train_actual_taken_i;
    logic [31:0] train_actual_target_i;
    logic [3:0]  train_ghr_snapshot_i;
    logic        recover_mispredict_pulse_i;
    logic [3:0]  recover_ghr_snapshot_i;
    logic        recover_actual_taken_i;
`ifdef BP_PERF_CNT_EN
    logic [31:0] stat_train_count_o;
    logic [31:0] stat_recover_count_o;
`endif

    bp_gshare_multi #(
        .GH(4), .PHT_BITS(4), .CTR_BITS(2), .BTB_BITS(4), .TAG_BITS(8), .FETCH_WIDTH(2)
    ) dut (
        .clock_i                    (clock_i),
        .reset_i                    (reset_i),
        .ready_o                    (ready_o),
        .predict_req_valid_i        (predict_req_valid_i),
        .predict_req_pc_i           (predict_req_pc_i),
        .predict_req_used_i         (predict_req_used_i),
        .predict_taken_o            (predict_taken_o),
        .predict_target_o           (predict_target_o),
        .predict_ghr_snapshot_o     (predict_ghr_snapshot_o),
        .train_valid_i              (train_valid_i),
        .train_pc_i                 (train_pc_i),
        .train_actual_taken_i       (train_actual_taken_i),
        .train_actual_target_i      (train_actual_target_i),
        .train_ghr_snapshot_i       (train_ghr_snapshot_i),
        .recover_mispredict_pulse_i (recover_mispredict_pulse_i),
        .recover_ghr_snapshot_i     (recover_ghr_snapshot_i),
        .recover_actual_taken_i     (recover_actual_taken_i)
`ifdef BP_PERF_CNT_EN
        ,
        .stat_train_count_o         (stat_train_count_o),
        .stat_recover_count_o       (stat_recover_count_o)
`endif
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    int n_tests;
    int n_fail;

    // Behavioural model state
    int          m_pht [16];
    bit          m_bv  [16];
    int          m_tag [16];
    logic [31:0] m_tgt [16];
    int          m_ghr;
    int          m_ntrain;
    int          m_nrec;
    logic [1:0]  e_tk;
    logic [63:0] e_tgt;
    logic [7:0]  e_sn;
    int          e_next;

    typedef struct {
        logic [1:0]  vld;
        logic [1:0]  used;
        logic [31:0] pc0;
        logic [31:0] pc1;
        logic        tv;
        logic [31:0] tpc;
        logic        tt;
        logic [31:0] ttgt;
        logic [3:0]  tsn;
        logic        rv;
        logic [3:0]  rsn;
        logic        rt;
        logic [1:0]  x_tk;
        logic [31:0] x_tg0;
        logic [31:0] x_tg1;
        logic [3:0]  x_sn0;
        logic [3:0]  x_sn1;
    } vec_t;

    vec_t tbl [13];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic clear_inputs();
        predict_req_valid_i        = '0;
        predict_req_used_i         = '0;
        predict_req_pc_i           = '0;
        train_valid_i              = 1'b0;
        train_pc_i                 = '0;
        train_actual_taken_i       = 1'b0;
        train_actual_target_i      = '0;
        train_ghr_snapshot_i       = '0;
        recover_mispredict_pulse_i = 1'b0;
        recover_ghr_snapshot_i     = '0;
        recover_actual_taken_i     = 1'b0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_pht[i] = 1;
            m_bv[i]  = 1'b0;
            m_tag[i] = 0;
            m_tgt[i] = '0;
        end
        m_ghr    = 0;
        m_ntrain = 0;
        m_nrec   = 0;
    endtask

    task automatic model_eval();
        int h;
        h = m_ghr;
        for (int i = 0; i < 2; i++) begin
            logic [31:0] pc;
            int          bi;
            int          pi;
            int          tg;
            logic        tk;
            pc = predict_req_pc_i[i*32 +: 32];
            bi = int'((pc >> 2) & 32'hF);
            pi = bi ^ h;
            tg = int'((pc >> 6) & 32'hFF);
            tk = predict_req_valid_i[i] && (m_pht[pi] >= 2) && m_bv[bi] && (m_tag[bi] == tg);
            e_tk[i]          = tk;
            e_tgt[i*32 +: 32] = tk ? m_tgt[bi] : 32'd0;
            e_sn[i*4 +: 4]   = 4'(h);
            if (predict_req_valid_i[i] && predict_req_used_i[i]) h = ((h * 2) + int'(tk)) % 16;
        end
        e_next = h;
    endtask

    task automatic model_commit();
        if (recover_mispredict_pulse_i) begin
            m_ghr = ((int'(recover_ghr_snapshot_i) * 2) + int'(recover_actual_taken_i)) % 16;
            m_nrec++;
        end else begin
            m_ghr = e_next;
        end
        if (train_valid_i) begin
            int bi;
            int pi;
            bi = int'((train_pc_i >> 2) & 32'hF);
            pi = bi ^ int'(train_ghr_snapshot_i);
            if (train_actual_taken_i) begin
                if (m_pht[pi] < 3) m_pht[pi]++;
                m_bv[bi]  = 1'b1;
                m_tag[bi] = int'((train_pc_i >> 6) & 32'hFF);
                m_tgt[bi] = train_actual_target_i;
            end else if (m_pht[pi] > 0) begin
                m_pht[pi]--;
            end
            m_ntrain++;
        end
    endtask

    // Counts edges until ready_o; injects predict/train/recover traffic mid-sweep that must be ignored.
    task automatic wait_ready(input string nm);
        int cnt;
        cnt = 0;
        while (ready_o !== 1'b1 && cnt < 200) begin
            if (cnt == 3) begin
                predict_req_valid_i        = 2'b01;
                predict_req_used_i         = 2'b11;
                predict_req_pc_i           = {32'h0, 32'h80};
                train_valid_i              = 1'b1;
                train_pc_i                 = 32'h80;
                train_actual_taken_i       = 1'b1;
                train_actual_target_i      = 32'h800;
                train_ghr_snapshot_i       = 4'h0;
                recover_mispredict_pulse_i = 1'b1;
                recover_ghr_snapshot_i     = 4'h5;
                recover_actual_taken_i     = 1'b1;
                #1;
                chk({nm, "_init_taken"}, predict_taken_o, 64'h0);
                chk({nm, "_init_target"}, predict_target_o, 64'h0);
                chk({nm, "_init_snap"}, predict_ghr_snapshot_o, 64'h0);
            end
            if (cnt == 4) clear_inputs();
            if (cnt == 6) chk({nm, "_init_ghr_held"}, predict_ghr_snapshot_o, 64'h0);
            @(posedge clock_i);
            @(negedge clock_i);
            cnt++;
        end
        clear_inputs();
        chk({nm, "_init_len"}, 64'(cnt), 64'd16);
    endtask

    task automatic apply(input vec_t v);
        predict_req_valid_i        = v.vld;
        predict_req_used_i         = v.used;
        predict_req_pc_i           = {v.pc1, v.pc0};
        train_valid_i              = v.tv;
        train_pc_i                 = v.tpc;
        train_actual_taken_i       = v.tt;
        train_actual_target_i      = v.ttgt;
        train_ghr_snapshot_i       = v.tsn;
        recover_mispredict_pulse_i = v.rv;
        recover_ghr_snapshot_i     = v.rsn;
        recover_actual_taken_i     = v.rt;
    endtask

    function automatic logic [31:0] rnd_pc();
        logic [31:0] p;
        p = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 3)) << 2);
        return p;
    endfunction

    task automatic random_phase(input string nm, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            predict_req_valid_i        = 2'($urandom_range(0, 3));
            predict_req_used_i         = 2'($urandom_range(0, 3));
            predict_req_pc_i           = {rnd_pc(), rnd_pc()};
            train_valid_i              = 1'($urandom_range(0, 1));
            train_pc_i                 = rnd_pc();
            train_actual_taken_i       = ($urandom_range(0, 2) != 0);
            train_actual_target_i      = $urandom;
            train_ghr_snapshot_i       = 4'($urandom_range(0, 15));
            recover_mispredict_pulse_i = ($urandom_range(0, 7) == 0);
            recover_ghr_snapshot_i     = 4'($urandom_range(0, 15));
            recover_actual_taken_i     = 1'($urandom_range(0, 1));
            #1;
            model_eval();
            chk({nm, "_taken"}, predict_taken_o, e_tk);
            chk({nm, "_target"}, predict_target_o, e_tgt);
            chk({nm, "_snap"}, predict_ghr_snapshot_o, e_sn);
`ifdef BP_PERF_CNT_EN
            chk({nm, "_stat_train"}, stat_train_count_o, 64'(m_ntrain));
            chk({nm, "_stat_recover"}, stat_recover_count_o, 64'(m_nrec));
`endif
            @(posedge clock_i);
            model_commit();
            @(negedge clock_i);
        end
        clear_inputs();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;

        //           vld    used   pc0       pc1       tv    tpc       tt    ttgt        tsn   rv    rsn   rt    x_tk   x_tg0      x_tg1  x_sn0 x_sn1
        tbl[0]  = '{2'b01, 2'b00, 32'h80,  32'h0,   1'b0, 32'h0,  1'b0, 32'h0,    4'h0, 1'b0, 4'h0, 1'b0, 2'b00, 32'h0,   32'h0, 4'h0, 4'h0};
        tbl[1]  = '{2'b00, 2'b00, 32'h0,   32'h0,   1'b1, 32'h80, 1'b1, 32'h800,  4'h0, 1'b0, 4'h0, 1'b0, 2'b00, 32'h0,   32'h0, 4'h0, 4'h0};
        tbl[2]  = '{2'b11, 2'b00, 32'h80,  32'h480, 1'b0, 32'h0,  1'b0, 32'h0,    4'h0, 1'b0, 4'h0, 1'b0, 2'b01, 32'h800, 32'h0, 4'h0, 4'h0};
        tbl[3]  = '{2'b11, 2'b11, 32'h80,  32'h100, 1'b0, 32'h0,  1'b0, 32'h0,    4'h0, 1'b0, 4'h0, 1'b0, 2'b01, 32'h800, 32'h0, 4'h0, 4'h1};
        tbl[4]  = '{2'b11, 2'b11, 32'h80,  32'h100, 1'b0, 32'h0,  1'b0, 32'h0,    4'h0, 1'b1, 4'h5, 1'b1, 2'b00, 32'h0,   32'h0, 4'h2, 4'h4};
        tbl[5]  = '{2'b00, 2'b00, 32'h0,   32'h0,   1'b1, 32'hC0, 1'b1, 32'hC00,  4'h0, 1'b1, 4'h0, 1'b0, 2'b00, 32'h0,   32'h0, 4'hB, 4'hB};
        tbl[6]  = '{2'b11, 2'b00, 32'hC0,  32'h80,  1'b1, 32'hC0, 1'b1, 32'hC00,  4'h0, 1'b0, 4'h0, 1'b0, 2'b01, 32'hC00, 32'h0, 4'h0, 4'h0};
        tbl[7]  = '{2'b00, 2'b00, 32'h0,   32'h0,   1'b1, 32'hC0, 1'b1, 32'hC00,  4'h0, 1'b0, 4'h0, 1'b0, 2'b00, 32'h0,   32'h0, 4'h0, 4'h0};
        tbl[8]  = '{2'b00, 2'b00, 32'h0,   32'h0,   1'b1, 32'hC0, 1'b1, 32'hC00,  4'h0, 1'b0, 4'h0, 1'b0, 2'b00, 32'h0,   32'h0, 4'h0, 4'h0};
        tbl[9]  = '{2'b00, 2'b00, 32'h0,   32'h0,   1'b1, 32'hC0, 1'b1, 32'hC00,  4'h0, 1'b0, 4'h0, 1'b0, 2'b00, 32'h0,   32'h0, 4'h0, 4'h0};
        tbl[10] = '{2'b11, 2'b00, 32'hC0,  32'h80,  1'b1, 32'hC0, 1'b0, 32'hDEAD, 4'h0, 1'b0, 4'h0, 1'b0, 2'b01, 32'hC00, 32'h0, 4'h0, 4'h0};
        tbl[11] = '{2'b11, 2'b00, 32'hC0,  32'h80,  1'b1, 32'hC0, 1'b0, 32'hDEAD, 4'h0, 1'b0, 4'h0, 1'b0, 2'b01, 32'hC00, 32'h0, 4'h0, 4'h0};
        tbl[12] = '{2'b11, 2'b00, 32'hC0,  32'h80,  1'b0, 32'h0,  1'b0, 32'h0,    4'h0, 1'b0, 4'h0, 1'b0, 2'b00, 32'h0,   32'h0, 4'h0, 4'h0};

        clear_inputs();
        reset_i = 1'b1;
        repeat (2) @(posedge clock_i);
        @(negedge clock_i);
        predict_req_valid_i = 2'b11;
        predict_req_pc_i    = {32'h80, 32'h80};
        #1;
        chk("rst_ready", ready_o, 64'h0);
        chk("rst_taken", predict_taken_o, 64'h0);
        chk("rst_target", predict_target_o, 64'h0);
        chk("rst_snap", predict_ghr_snapshot_o, 64'h0);
        clear_inputs();
        reset_i = 1'b0;
        model_reset();
        wait_ready("boot");
        chk("boot_ready_high", ready_o, 64'h1);

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i]);
            #1;
            model_eval();
            chk($sformatf("tbl%0d_taken", i), predict_taken_o, tbl[i].x_tk);
            chk($sformatf("tbl%0d_target", i), predict_target_o, {tbl[i].x_tg1, tbl[i].x_tg0});
            chk($sformatf("tbl%0d_snap", i), predict_ghr_snapshot_o, {tbl[i].x_sn1, tbl[i].x_sn0});
`ifdef BP_PERF_CNT_EN
            chk($sformatf("tbl%0d_stat_train", i), stat_train_count_o, 64'(m_ntrain));
            chk($sformatf("tbl%0d_stat_recover", i), stat_recover_count_o, 64'(m_nrec));
`endif
            @(posedge clock_i);
            model_commit();
            @(negedge clock_i);
        end
        clear_inputs();

        random_phase("rnd", 300);

        reset_i = 1'b1;
        @(posedge clock_i);
        @(negedge clock_i);
        #1;
        chk("midrst_ready", ready_o, 64'h0);
        reset_i = 1'b0;
        model_reset();
        wait_ready("midrst");

        random_phase("rnd2", 150);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
